// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared front-end constants, opcodes and fetch FSM states
package rv_core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {instr, pc} holding slot for responses that land during a stall
module fetch_skid_buffer #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic             clear_i,
  input  logic [INS_W-1:0] instr_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             valid_o,
  output logic [INS_W-1:0] instr_o,
  output logic [PC_W-1:0]  pc_o
);

  logic             valid_q;
  logic [INS_W-1:0] instr_q;
  logic [PC_W-1:0]  pc_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, imem request/valid fetch FSM and IF/ID register
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr
);

  localparam logic [INS_W-1:0] NOP_W = INS_W'(NOP_INSTR);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  drain_addr_q;
  logic             id_valid_q;
  logic [PC_W-1:0]  id_pc_q;
  logic [INS_W-1:0] id_instr_q;

  logic             skid_load;
  logic             skid_unload;
  logic             skid_valid;
  logic [INS_W-1:0] skid_instr;
  logic [PC_W-1:0]  skid_pc;

  assign skid_load   = (state_q == FETCH) && imem_valid && stall && !redirect;
  assign skid_unload = (state_q == HOLD) && !stall && !redirect;

  fetch_skid_buffer #(.PC_W(PC_W), .INS_W(INS_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect),
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  // DRAIN must keep presenting the pre-redirect address until the old response returns
  assign imem_req  = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP_W;
    end else if (redirect) begin
      pc_q       <= redirect_pc & ~PC_W'(3);
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_W;
      if (state_q == FETCH && !imem_valid) begin
        state_q      <= DRAIN;
        drain_addr_q <= pc_q;
      end else if (state_q != DRAIN) begin
        state_q <= FETCH;
      end
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_valid) begin
            pc_q <= pc_q + PC_W'(4);
            if (stall) begin
              state_q <= HOLD;
            end else begin
              id_valid_q <= 1'b1;
              id_pc_q    <= pc_q;
              id_instr_q <= imem_rdata;
            end
          end else if (!stall) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_W;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_q <= skid_valid;
            id_pc_q    <= skid_pc;
            id_instr_q <= skid_valid ? skid_instr : NOP_W;
            state_q    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_valid) state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the main decoder. It owns the PC and fetches 32-bit instructions over a request/valid instruction-memory handshake.
- It holds them in the IF/ID register, whose id_instr[6:0] drives the decoder's Opcode input.
- It supports hazard-unit stalls and branch/jal redirects, with squash of in-flight fetches.

Parameters:
- PC_W, 9, PC/address width in bits (byte address); PC wraps modulo 2^PC_W.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold IF/ID contents and stop PC advance
- redirect  in  1  branch/jal taken: flush IF/ID, load PC from redirect_pc
- redirect_pc  in  PC_W  redirect target; bits[1:0] forced to 0 internally
- imem_req  out  1  fetch request, held high until imem_valid
- imem_addr  out  PC_W  fetch address, stable while imem_req=1
- imem_rdata  in  INS_W  fetched instruction, qualified by imem_valid
- imem_valid  in  1  response; may assert in the same cycle as imem_req (zero-wait)
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  PC_W  PC of id_instr
- id_instr  out  INS_W  IF/ID instruction; NOP 32'h00000013 when id_valid=0

Behaviour:
- Reset (synchronous, every output), next cycle:
  - pc_q=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_instr=NOP, id_pc=0, skid buffer empty.
  - Reset mid-fetch: the response is dropped; imem_req falls in the same cycle reset is sampled.
- States:
  - IDLE: imem_req=0. The cycle after reset deasserts, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_q.
    - imem_valid & !stall: load IF/ID with id_instr=imem_rdata, id_pc=pc_q, id_valid=1. pc_q+=4. Stay in FETCH. Throughput is 1 instr/cycle with zero-wait memory.
    - imem_valid & stall: capture into the skid buffer (instr, pc). pc_q+=4. Go to HOLD. IF/ID unchanged.
    - !imem_valid & !stall: IF/ID loads a bubble (id_valid=0, NOP).
    - !imem_valid & stall: IF/ID holds.
  - HOLD: imem_req=0. IF/ID holds while stall=1.
    - When stall=0: move skid to IF/ID (id_valid=1) and go to FETCH.
  - DRAIN: imem_req=1 with the old address (protocol: the address may not change before valid).
    - On imem_valid: discard the data and go to FETCH at the new pc_q.
- Redirect has highest priority over stall and over any imem_valid in that cycle. Next cycle:
  - IF/ID becomes a bubble.
  - The skid buffer is emptied.
  - pc_q={redirect_pc[PC_W-1:2],2'b00}.
- Redirect state transitions:
  - From FETCH without imem_valid that cycle: go to DRAIN.
  - Otherwise (FETCH with same-cycle imem_valid, HOLD, IDLE): go to FETCH. The response is squashed.
- Redirect penalty: the target is requested the cycle after redirect with zero-wait memory. Exactly one bubble reaches the decoder per redirect beyond the already-fetched wrong-path slot.
- Redirect during DRAIN: update pc_q and stay in DRAIN.
- PC wrap: pc_q=2^PC_W-4, then +4 gives 0. No flag.
- Stall and redirect together: redirect wins; stall is ignored that cycle.
- No instruction is ever duplicated or lost. With no redirect, the id_pc sequence seen with id_valid=1 is strictly +4 apart.

Decomposition:
- Package rv_core_pkg:
  - NOP_INSTR constant.
  - Opcode constants (R_TYPE, LW, SW, BR, IMM, JAL), shared with the decoder.
  - fetch_state_t enum {IDLE, FETCH, HOLD, DRAIN}.
- One sub-module, fetch_skid_buffer: a 1-entry buffer for {instr, pc} with load, unload and clear.
- The FSM, PC and IF/ID register stay in instr_fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning mem[a]=a ^ 32'hA5A5_0000, stall=0 → imem_addr 0,4,8,... on consecutive cycles; id_pc=0,4,8 with id_valid=1 from the 2nd cycle after reset release; id_instr=NOP while id_valid=0.
- 2-cycle-latency memory → id_valid pattern 0,0,1 repeating; imem_addr held stable across wait cycles; pc advances only on valid.
- stall=1 for 3 cycles while a response arrives at pc=0x10 → IF/ID holds 0x0C; imem_req=0 during HOLD; after release id_pc=0x10, then 0x14; no duplicate or lost PC.
- redirect=1 with redirect_pc=0x43 and same-cycle imem_valid → next cycle id_valid=0 and imem_addr=0x40; the squashed instruction never appears on id_instr.
- redirect=1 to 0x80 with a 3-cycle-latency fetch outstanding → DRAIN keeps the old imem_addr until valid; the response is discarded; the next request is 0x80.
- Simultaneous stall=1 and redirect=1 while in HOLD → skid cleared, pc_q=target, IF/ID bubble; RESET_PC=0x1FC with PC_W=9 → fetch order 0x1FC, 0x000.
